execute_stage: RTL and testbench
================================

// Module: execute_stage
// PURPOSE
//  Pipeline stage directly upstream of memory_stage. Selects the ALU operand, computes the
//  result (single-cycle ops, plus iterative 32-step MUL/DIVU), evaluates the branch condition,
//  and drives the registered EX/MEM outputs (alu_result, valB, signals) into memory_stage.
//  Honours memory_stage's stall and raises busy to freeze the upstream decode stage.
// PARAMETERS
//  WIDTH   32   datapath width; iterative MUL/DIVU take WIDTH steps
// PORTS
//  clock          in   1      single clock, rising edge
//  reset          in   1      synchronous, active-high
//  in_valid       in   1      upstream presents an instruction
//  valA           in   32     register operand A
//  valB           in   32     register operand B / store data
//  imm            in   32     sign-extended [15:0]
//  pc_plus4       in   32     PC of instruction + 4
//  alu_op         in   4      0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLT,6 SLL,7 SRL,8 MUL,9 DIVU; others=ADD
//  signals        in   8      control bits, same layout as memory_stage ([7] ALUSrc .. [0] goto_flg)
//  mem_stall      in   1      stall from memory_stage
//  busy           out  1      upstream must hold; input consumed only on edge with in_valid & !busy
//  alu_result     out  32     registered result -> memory_stage.alu_result
//  valB_out       out  32     registered valB -> memory_stage.valB
//  signals_out    out  8      registered signals -> memory_stage.signals (0 = bubble)
//  out_valid      out  1      registered: outputs carry a real instruction
//  branch_taken   out  1      registered: signals[2] & (signals[1] ? zero : !zero)
//  branch_target  out  32     registered: pc_plus4 + (imm << 2)
// BEHAVIOUR
//  - Reset: every output register 0, state IDLE, iteration counter 0; busy follows equation below.
//  - opB = signals[7] ? imm : valB. zero = (valA - opB == 0), used for branch only.
//  - SLT signed compare -> 1/0. SLL/SRL shift valA by opB[4:0]. ADD/SUB wrap modulo 2^32.
//  - MUL: low 32 bits of valA*opB, shift-add, WIDTH steps. DIVU: unsigned quotient,
//    restoring, WIDTH steps; opB==0 -> result 32'hFFFFFFFF.
//  - FSM states IDLE, MULT, DIVI, DONE.
//    IDLE: accept when in_valid & !busy. Single-cycle op -> outputs load next edge, out_valid=1.
//          MUL/DIVU -> latch valA, opB, valB, signals, pc_plus4, imm; counter=0; go MULT/DIVI;
//          outputs load a bubble this edge.
//    MULT/DIVI: one step per edge; after step WIDTH go DONE. Steps continue while mem_stall=1.
//    DONE: if !mem_stall, load the latched result into the outputs, out_valid=1, go IDLE;
//          else hold in DONE.
//  - Latency: single-cycle op visible 1 edge after accept. MUL/DIVU visible WIDTH+1 edges
//    after the accept edge (33 for WIDTH=32) when no mem_stall.
//  - busy = mem_stall | (state != IDLE).
//  - Output registers hold while mem_stall=1, regardless of state.
//  - Bubble (!mem_stall and no result to load): out_valid=0, signals_out=0,
//    branch_taken=0; alu_result, valB_out and branch_target hold.
//  - reset asserted mid-MUL/DIVU aborts: IDLE, outputs 0, no partial result emitted.
//  - in_valid with busy=1 is ignored; upstream keeps presenting the same instruction.
// TESTING
//  1. ADD valA=5, imm=7, signals[7]=1 -> next edge alu_result=12, out_valid=1,
//     signals_out=signals.
//  2. SUB valA=valB=9, signals[2]=1, signals[1]=1, pc_plus4=0x100, imm=3 -> branch_taken=1,
//     branch_target=0x10C, alu_result=0.
//  3. MUL 0xFFFF*0x10001 -> busy 1 for 33 cycles, then alu_result=0xFFFFFFFF, out_valid=1;
//     bubble outputs in between.
//  4. DIVU 100/7 -> 14; DIVU x/0 -> 0xFFFFFFFF.
//  5. mem_stall=1 for 4 cycles after an ADD result -> outputs frozen, busy=1,
//     next instruction not consumed until stall drops.
//  6. reset asserted at step 10 of a DIVU -> next edge all outputs 0, state IDLE,
//     busy=mem_stall.

Source files
------------

// File: rtl/execute_stage.sv
// EX stage feeding memory_stage: operand select, single-cycle ALU, iterative MUL/DIVU,
// branch resolution and the registered EX/MEM outputs.
module execute_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] valA,
    input  logic [WIDTH-1:0] valB,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] pc_plus4,
    input  logic [3:0]       alu_op,
    input  logic [7:0]       signals,
    input  logic             mem_stall,
    output logic             busy,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] valB_out,
    output logic [7:0]       signals_out,
    output logic             out_valid,
    output logic             branch_taken,
    output logic [WIDTH-1:0] branch_target
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int SW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, MULT, DIVI, DONE} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    step_cnt;
    logic [WIDTH-1:0] op_b, alu_comb, target_comb, iter_result;
    logic             zero, taken_comb, accept, is_iter, last_step;

    // Iterative workspace: work_x is multiplicand (MUL) or dividend/quotient (DIVU),
    // work_y is multiplier (MUL) or divisor (DIVU).
    logic [WIDTH-1:0] mul_acc, work_x, work_y, rem;
    logic [WIDTH:0]   rem_shift, div_sub;
    logic [WIDTH-1:0] lat_valb, lat_target;
    logic [7:0]       lat_signals;
    logic             lat_taken, lat_div;

    assign op_b        = signals[7] ? imm : valB;
    assign zero        = (valA - op_b) == '0;
    assign taken_comb  = signals[2] & (signals[1] ? zero : !zero);
    assign target_comb = pc_plus4 + (imm << 2);
    assign busy        = mem_stall | (state != IDLE);
    assign accept      = in_valid & !busy;
    assign is_iter     = (alu_op == 4'd8) || (alu_op == 4'd9);
    assign last_step   = step_cnt == CW'(WIDTH - 1);
    assign rem_shift   = {rem, work_x[WIDTH-1]};
    assign div_sub     = rem_shift - {1'b0, work_y};
    assign iter_result = !lat_div ? mul_acc : ((work_y == '0) ? '1 : work_x);

    always_comb begin
        alu_comb = valA + op_b;
        case (alu_op)
            4'd1: alu_comb = valA - op_b;
            4'd2: alu_comb = valA & op_b;
            4'd3: alu_comb = valA | op_b;
            4'd4: alu_comb = valA ^ op_b;
            4'd5: alu_comb = {{(WIDTH-1){1'b0}}, ($signed(valA) < $signed(op_b))};
            4'd6: alu_comb = valA << op_b[SW-1:0];
            4'd7: alu_comb = valA >> op_b[SW-1:0];
            default: alu_comb = valA + op_b;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (accept && is_iter) state_next = (alu_op == 4'd9) ? DIVI : MULT;
            MULT, DIVI: if (last_step) state_next = DONE;
            DONE:       if (!mem_stall) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // The iterative engine keeps stepping during mem_stall; only the DONE hand-off waits.
    always_ff @(posedge clock) begin
        if (reset) begin
            step_cnt    <= '0;
            mul_acc     <= '0;
            work_x      <= '0;
            work_y      <= '0;
            rem         <= '0;
            lat_valb    <= '0;
            lat_target  <= '0;
            lat_signals <= '0;
            lat_taken   <= 1'b0;
            lat_div     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept && is_iter) begin
                    step_cnt    <= '0;
                    mul_acc     <= '0;
                    rem         <= '0;
                    work_x      <= valA;
                    work_y      <= op_b;
                    lat_valb    <= valB;
                    lat_target  <= target_comb;
                    lat_signals <= signals;
                    lat_taken   <= taken_comb;
                    lat_div     <= (alu_op == 4'd9);
                end
                MULT: begin
                    if (work_y[0]) mul_acc <= mul_acc + work_x;
                    work_x   <= work_x << 1;
                    work_y   <= work_y >> 1;
                    step_cnt <= step_cnt + 1'b1;
                end
                DIVI: begin
                    rem      <= div_sub[WIDTH] ? rem_shift[WIDTH-1:0] : div_sub[WIDTH-1:0];
                    work_x   <= {work_x[WIDTH-2:0], !div_sub[WIDTH]};
                    step_cnt <= step_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            alu_result    <= '0;
            valB_out      <= '0;
            signals_out   <= '0;
            out_valid     <= 1'b0;
            branch_taken  <= 1'b0;
            branch_target <= '0;
        end else if (!mem_stall) begin
            if (state == DONE) begin
                alu_result    <= iter_result;
                valB_out      <= lat_valb;
                signals_out   <= lat_signals;
                out_valid     <= 1'b1;
                branch_taken  <= lat_taken;
                branch_target <= lat_target;
            end else if (accept && !is_iter) begin
                alu_result    <= alu_comb;
                valB_out      <= valB;
                signals_out   <= signals;
                out_valid     <= 1'b1;
                branch_taken  <= taken_comb;
                branch_target <= target_comb;
            end else begin
                signals_out  <= '0;
                out_valid    <= 1'b0;
                branch_taken <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage with hand-computed expectations.
module tb_execute_stage;

    logic        clock = 1'b0;
    logic        reset, in_valid, mem_stall;
    logic [31:0] valA, valB, imm, pc_plus4;
    logic [3:0]  alu_op;
    logic [7:0]  signals;
    logic        busy, out_valid, branch_taken;
    logic [31:0] alu_result, valB_out, branch_target;
    logic [7:0]  signals_out;

    int total = 0;
    int bad   = 0;

    execute_stage #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid),
        .valA(valA), .valB(valB), .imm(imm), .pc_plus4(pc_plus4),
        .alu_op(alu_op), .signals(signals), .mem_stall(mem_stall),
        .busy(busy), .alu_result(alu_result), .valB_out(valB_out),
        .signals_out(signals_out), .out_valid(out_valid),
        .branch_taken(branch_taken), .branch_target(branch_target)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] im,
                                 input logic [31:0] pc, input logic [7:0] sig);
        in_valid = v;
        alu_op   = op;
        valA     = a;
        valB     = b;
        imm      = im;
        pc_plus4 = pc;
        signals  = sig;
    endtask

    task automatic runSingle(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] im, input logic [7:0] sig,
                             input logic [31:0] expRes, input logic expTaken);
        applyStimulus(1'b1, op, a, b, im, 32'h0, sig);
        tick();
        checkOutput({tag, "_res"}, alu_result, expRes);
        checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        checkOutput({tag, "_sig"}, {24'b0, signals_out}, {24'b0, sig});
        checkOutput({tag, "_taken"}, {31'b0, branch_taken}, {31'b0, expTaken});
    endtask

    // Accept one MUL/DIVU, then count busy cycles until the result emerges.
    task automatic runIter(input string tag, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [7:0] sig, input logic [31:0] expRes);
        int busyCycles = 0;
        int leaks = 0;
        applyStimulus(1'b1, op, a, b, 32'h0, 32'h0, sig);
        tick();
        in_valid = 1'b0;
        while (busy && busyCycles < 100) begin
            busyCycles++;
            if (out_valid) leaks++;
            tick();
        end
        checkOutput({tag, "_busy_cycles"}, busyCycles, 32'd33);
        checkOutput({tag, "_bubbles"}, leaks, 32'd0);
        checkOutput({tag, "_res"}, alu_result, expRes);
        checkOutput({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
        checkOutput({tag, "_sig"}, {24'b0, signals_out}, {24'b0, sig});
        checkOutput({tag, "_valb"}, valB_out, b);
    endtask

    initial begin
        int seen;
        reset     = 1'b1;
        mem_stall = 1'b0;
        applyStimulus(1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 8'h00);
        tick();
        tick();
        checkOutput("rst_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("rst_res", alu_result, 32'd0);
        checkOutput("rst_sig", {24'b0, signals_out}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;

        runSingle("add",      4'd0, 32'd5,        32'd0,        32'd7,  8'h80, 32'd12,       1'b0);
        runSingle("and",      4'd2, 32'h0000F0F0, 32'h0000FF00, 32'd0,  8'h00, 32'h0000F000, 1'b0);
        runSingle("or",       4'd3, 32'h0000F0F0, 32'h00000F0F, 32'd0,  8'h00, 32'h0000FFFF, 1'b0);
        runSingle("xor",      4'd4, 32'hFF00FF00, 32'h0FF00FF0, 32'd0,  8'h00, 32'hF0F0F0F0, 1'b0);
        runSingle("slt_neg",  4'd5, 32'hFFFFFFFF, 32'd1,        32'd0,  8'h00, 32'd1,        1'b0);
        runSingle("slt_pos",  4'd5, 32'd1,        32'hFFFFFFFF, 32'd0,  8'h00, 32'd0,        1'b0);
        runSingle("sll",      4'd6, 32'd1,        32'd0,        32'd4,  8'h80, 32'd16,       1'b0);
        runSingle("srl",      4'd7, 32'h80000000, 32'h0000003F, 32'd0,  8'h00, 32'd1,        1'b0);
        runSingle("sub_wrap", 4'd1, 32'd0,        32'd1,        32'd0,  8'h00, 32'hFFFFFFFF, 1'b0);
        runSingle("add_wrap", 4'd0, 32'hFFFFFFFF, 32'd2,        32'd0,  8'h00, 32'd1,        1'b0);
        runSingle("op_dflt",  4'd15, 32'd3,       32'd4,        32'd0,  8'h00, 32'd7,        1'b0);
        runSingle("bne_take", 4'd1, 32'd3,        32'd4,        32'd0,  8'h04, 32'hFFFFFFFF, 1'b1);
        runSingle("beq_not",  4'd1, 32'd3,        32'd4,        32'd0,  8'h06, 32'hFFFFFFFF, 1'b0);

        applyStimulus(1'b1, 4'd1, 32'd9, 32'd9, 32'd3, 32'h100, 8'h06);
        tick();
        checkOutput("beq_res", alu_result, 32'd0);
        checkOutput("beq_taken", {31'b0, branch_taken}, 32'd1);
        checkOutput("beq_target", branch_target, 32'h10C);
        checkOutput("beq_valb", valB_out, 32'd9);

        in_valid = 1'b0;
        tick();
        checkOutput("bubble_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("bubble_sig", {24'b0, signals_out}, 32'd0);
        checkOutput("bubble_taken", {31'b0, branch_taken}, 32'd0);
        checkOutput("bubble_hold_res", alu_result, 32'd0);
        checkOutput("bubble_hold_tgt", branch_target, 32'h10C);

        runIter("mul",     4'd8, 32'h0000FFFF, 32'h00010001, 8'h08, 32'hFFFFFFFF);
        runIter("divu",    4'd9, 32'd100,      32'd7,        8'h10, 32'd14);
        runIter("divu_z",  4'd9, 32'd12345,    32'd0,        8'h20, 32'hFFFFFFFF);

        // Stall after an ADD result: outputs freeze and the next ADD waits.
        runSingle("pre_stall", 4'd0, 32'd1, 32'd0, 32'd2, 8'h80, 32'd3, 1'b0);
        applyStimulus(1'b1, 4'd0, 32'd10, 32'd0, 32'd20, 32'h0, 8'h81);
        mem_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("stall_res", alu_result, 32'd3);
            checkOutput("stall_valid", {31'b0, out_valid}, 32'd1);
            checkOutput("stall_busy", {31'b0, busy}, 32'd1);
        end
        mem_stall = 1'b0;
        tick();
        checkOutput("post_stall_res", alu_result, 32'd30);
        checkOutput("post_stall_sig", {24'b0, signals_out}, 32'h81);
        in_valid = 1'b0;
        tick();

        // DIVU keeps iterating under a long stall; result appears one edge after release.
        applyStimulus(1'b1, 4'd9, 32'd1000, 32'd10, 32'd0, 32'h0, 8'h40);
        tick();
        in_valid  = 1'b0;
        mem_stall = 1'b1;
        repeat (40) tick();
        checkOutput("dstall_valid", {31'b0, out_valid}, 32'd0);
        mem_stall = 1'b0;
        tick();
        checkOutput("dstall_res", alu_result, 32'd100);
        checkOutput("dstall_out_valid", {31'b0, out_valid}, 32'd1);

        // Reset at step 10 of a DIVU aborts it.
        applyStimulus(1'b1, 4'd9, 32'd1000, 32'd3, 32'd0, 32'h0, 8'h20);
        tick();
        in_valid = 1'b0;
        repeat (10) tick();
        checkOutput("abort_pre_busy", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        checkOutput("abort_res", alu_result, 32'd0);
        checkOutput("abort_valid", {31'b0, out_valid}, 32'd0);
        checkOutput("abort_valb", valB_out, 32'd0);
        checkOutput("abort_target", branch_target, 32'd0);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_valid || busy) seen++;
        end
        checkOutput("abort_no_partial", seen, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
